// File: rtl/jtpopeye_objbuf.sv
// jtpopeye_objbuf
// Double-buffered object line buffer feeding the colour mixer.
// While one bank is displayed (read by hdump, each location cleared right
// after it is read), the object engine fills the other bank for the next
// line. The banks swap on the falling edge of HBD_n.
//
// Ports
//   clk      system clock
//   rst      synchronous active-high reset (restarts the full RAM clear)
//   cen      pixel clock enable, all state advances only when high
//   HBD_n    horizontal blank (active low), falling edge swaps banks
//   hdump    read position in the visible bank
//   obj_we   object pixel write strobe
//   obj_x    write position in the hidden bank
//   obj_pxl  pixel {colour[5:0], value[1:0]}, value 0 is transparent
//   objc     colour to the mixer
//   objv     pixel value to the mixer, 0 means no object
//   busy     high while the reset clear runs, writes are ignored then
//
// Build option
//   JTPOPEYE_OBJ_FIRSTWIN_EN  defined: first written pixel keeps priority
//                             undefined: last written pixel wins
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_CLEAR | zeroing both banks, one entry per cen; outputs forced to 0
// ST_RUN   | normal operation: display reads, object writes, swaps

module jtpopeye_objbuf #(
    parameter int AW   = 9,
    parameter int CLRW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cen,
    input  logic            HBD_n,
    input  logic [AW-1:0]   hdump,
    input  logic            obj_we,
    input  logic [AW-1:0]   obj_x,
    input  logic [CLRW-1:0] obj_pxl,
    output logic [5:0]      objc,
    output logic [1:0]      objv,
    output logic            busy
);

    localparam int DEPTH = 2 * (2 ** AW);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [CLRW-1:0] r_mem [0:DEPTH-1];

    logic [AW:0]     r_clr_cnt;
    logic            w_clr_last;
    logic            w_run;

    logic            r_disp;
    logic            r_hbd_l;
    logic            w_swap;

    logic [CLRW-1:0] r_rd_data;
    logic [AW:0]     r_rd_loc;
    logic            r_rd_vld;
    logic [AW:0]     w_rd_loc;
    logic            w_rd_hit_clr;

    logic            r_s1_vld;
    logic [AW:0]     r_s1_loc;
    logic [CLRW-1:0] r_s1_pxl;
    logic            w_s1_en;
    logic [AW:0]     w_s1_loc;
    logic            w_s2_we;

    assign w_clr_last = (r_clr_cnt == {(AW+1){1'b1}});
    assign w_run      = (r_state == ST_RUN);
    assign w_swap     = r_hbd_l & ~HBD_n;

    // Bank select is the MSB of the RAM location.
    assign w_rd_loc     = {r_disp, hdump};
    // The location read last cycle is being zeroed on this edge, so a
    // repeated read of it must already see 0.
    assign w_rd_hit_clr = r_rd_vld && (r_rd_loc == w_rd_loc);

    assign w_s1_en  = w_run && obj_we && (obj_pxl[1:0] != 2'd0);
    // The hidden bank is sampled when the write is issued, so a write issued
    // on the swap cycle still targets the bank that is becoming visible.
    assign w_s1_loc = {~r_disp, obj_x};

`ifdef JTPOPEYE_OBJ_FIRSTWIN_EN
    logic [1:0] r_s1_oldv;

    assign w_s2_we = r_s1_vld && (r_s1_oldv == 2'd0);
`else
    assign w_s2_we = r_s1_vld;
`endif

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_CLEAR;
        end else if (cen) begin
            r_state <= w_state_nxt;
        end
    end

    // FSM: next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_CLEAR: if (w_clr_last) w_state_nxt = ST_RUN;
            ST_RUN:   w_state_nxt = ST_RUN;
            default:  w_state_nxt = ST_CLEAR;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy = 1'b0;
        if (r_state == ST_CLEAR) busy = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_clr_cnt <= '0;
        end else if (cen && !w_run) begin
            r_clr_cnt <= r_clr_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hbd_l <= 1'b0;
            r_disp  <= 1'b0;
        end else if (cen) begin
            r_hbd_l <= HBD_n;
            if (w_swap) r_disp <= ~r_disp;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data <= '0;
            r_rd_loc  <= '0;
            r_rd_vld  <= 1'b0;
        end else if (cen) begin
            if (w_run) begin
                r_rd_data <= w_rd_hit_clr ? '0 : r_mem[w_rd_loc];
                r_rd_loc  <= w_rd_loc;
                r_rd_vld  <= 1'b1;
            end else begin
                r_rd_data <= '0;
                r_rd_vld  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_vld <= 1'b0;
            r_s1_loc <= '0;
            r_s1_pxl <= '0;
`ifdef JTPOPEYE_OBJ_FIRSTWIN_EN
            r_s1_oldv <= 2'd0;
`endif
        end else if (cen) begin
            r_s1_vld <= w_s1_en;
            if (w_s1_en) begin
                r_s1_loc <= w_s1_loc;
                r_s1_pxl <= obj_pxl;
`ifdef JTPOPEYE_OBJ_FIRSTWIN_EN
                // Stage 2 is writing the same location on this edge: take its
                // data instead of the RAM word, which is about to go stale.
                if (w_s2_we && (r_s1_loc == w_s1_loc))
                    r_s1_oldv <= r_s1_pxl[1:0];
                else
                    r_s1_oldv <= r_mem[w_s1_loc][1:0];
`endif
            end
        end
    end

    // RAM writes. Later statements take precedence, so an object pixel
    // landing on a location that is also being read-cleared is kept.
    always_ff @(posedge clk) begin
        if (cen && !rst) begin
            if (!w_run)   r_mem[r_clr_cnt] <= '0;
            if (r_rd_vld) r_mem[r_rd_loc]  <= '0;
            if (w_s2_we)  r_mem[r_s1_loc]  <= r_s1_pxl;
        end
    end

    assign objc = r_rd_data[CLRW-1 -: 6];
    assign objv = r_rd_data[1:0];

endmodule

// File: tb/tb_jtpopeye_objbuf.sv
module tb_jtpopeye_objbuf;

    localparam int AW   = 9;
    localparam int CLRW = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            cen;
    logic            HBD_n;
    logic [AW-1:0]   hdump;
    logic            obj_we;
    logic [AW-1:0]   obj_x;
    logic [CLRW-1:0] obj_pxl;
    logic [5:0]      objc;
    logic [1:0]      objv;
    logic            busy;

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0] exp_q [$];

    jtpopeye_objbuf #(.AW(AW), .CLRW(CLRW)) dut (
        .clk     (clk),
        .rst     (rst),
        .cen     (cen),
        .HBD_n   (HBD_n),
        .hdump   (hdump),
        .obj_we  (obj_we),
        .obj_x   (obj_x),
        .obj_pxl (obj_pxl),
        .objc    (objc),
        .objv    (objv),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic park();
        hdump = 9'h1FF;
    endtask

    task automatic read_px(input logic [AW-1:0] a, output logic [7:0] got);
        hdump = a;
        step();
        got = {objc, objv};
    endtask

    task automatic wr(input logic [AW-1:0] x, input logic [7:0] p);
        obj_we  = 1'b1;
        obj_x   = x;
        obj_pxl = p;
        step();
        obj_we  = 1'b0;
    endtask

    task automatic swap();
        HBD_n = 1'b0;
        step();
        HBD_n = 1'b1;
        step();
    endtask

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 1100) begin
            step();
            n++;
        end
        n_chk++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: busy=%b after %0d cycles, required 0", name, busy, n);
        end
    endtask

    task automatic fill_hidden(input logic [7:0] p);
        hdump   = '0;
        obj_we  = 1'b1;
        obj_pxl = p;
        for (int i = 0; i < 512; i++) begin
            obj_x = i[AW-1:0];
            step();
        end
        obj_we = 1'b0;
        step();
        step();
    endtask

    task automatic test_reset();
        int n;
        int bad_out;
        logic [7:0] got;
        logic [7:0] e;
        // pre-fill both banks with 0xFF through the normal write path
        fill_hidden(8'hFF);
        swap();
        fill_hidden(8'hFF);
        rst = 1'b1;
        step();
        step();
        n_chk++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_busy: got %b, required 1", busy);
        end
        n_chk++;
        if ({objc, objv} !== 8'h00) begin
            n_fail++;
            $display("FAIL rst_out: got %h, required 00", {objc, objv});
        end
        // writes held on for the whole clear must be ignored
        rst     = 1'b0;
        obj_we  = 1'b1;
        obj_x   = 9'h1F0;
        obj_pxl = 8'hFF;
        for (int i = 0; i < 300; i++) step();
        n_chk++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL midclear_busy: got %b, required 1", busy);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n = 0;
        bad_out = 0;
        while (n < 1100) begin
            step();
            n++;
            if (busy === 1'b0) break;
            if ({objc, objv} !== 8'h00) bad_out++;
        end
        obj_we = 1'b0;
        n_chk++;
        if (n != 1024 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_len: busy high for %0d cycles (busy=%b), required 1024", n, busy);
        end
        n_chk++;
        if (bad_out != 0) begin
            n_fail++;
            $display("FAIL clear_out: %0d cycles with nonzero output, required 0", bad_out);
        end
        for (int a = 0; a < 512; a++) begin
            exp_q.push_back(8'h00);
            read_px(a[AW-1:0], got);
            e = exp_q.pop_front();
            n_chk++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL clr_bank0[%0d]: got %h, required %h", a, got, e);
            end
        end
        park();
        swap();
        for (int a = 0; a < 512; a++) begin
            exp_q.push_back(8'h00);
            read_px(a[AW-1:0], got);
            e = exp_q.pop_front();
            n_chk++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL clr_bank1[%0d]: got %h, required %h", a, got, e);
            end
        end
        park();
        step();
    endtask

    task automatic test_write_swap_read();
        logic [7:0] got;
        logic [7:0] e;
        wr(9'h010, 8'hA7);
        step();
        swap();
        exp_q.push_back(8'hA7);
        read_px(9'h010, got);
        e = exp_q.pop_front();
        n_chk++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL wsr_read: got %h, required %h", got, e);
        end
        n_chk++;
        if (objc !== 6'h29 || objv !== 2'd3) begin
            n_fail++;
            $display("FAIL wsr_fields: objc=%h objv=%0d, required objc=29 objv=3", objc, objv);
        end
        exp_q.push_back(8'h00);
        read_px(9'h010, got);
        e = exp_q.pop_front();
        n_chk++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL wsr_reread: got %h, required %h", got, e);
        end
        park();
        step();
    endtask

    task automatic test_transparent();
        logic [7:0] got;
        logic [7:0] e;
        wr(9'h020, 8'h55);
        wr(9'h020, 8'h54);
        step();
        swap();
        exp_q.push_back(8'h55);
        read_px(9'h020, got);
        e = exp_q.pop_front();
        n_chk++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL transparent: got %h, required %h", got, e);
        end
        park();
        step();
    endtask

    task automatic test_priority();
        logic [7:0] got;
        logic [7:0] e;
        wr(9'h030, 8'h41);
        wr(9'h030, 8'h82);
        step();
        step();
        swap();
`ifdef JTPOPEYE_OBJ_FIRSTWIN_EN
        exp_q.push_back(8'h41);
`else
        exp_q.push_back(8'h82);
`endif
        read_px(9'h030, got);
        e = exp_q.pop_front();
        n_chk++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL priority: got %h, required %h", got, e);
        end
        park();
        step();
    endtask

    task automatic test_back_to_back();
        logic [7:0] got;
        logic [7:0] e;
        logic [7:0] p;
        obj_we = 1'b1;
        for (int i = 0; i < 8; i++) begin
            obj_x   = 9'h080 + i[AW-1:0];
            obj_pxl = {i[5:0] + 6'd1, 2'(i % 3 + 1)};
            step();
        end
        obj_we = 1'b0;
        step();
        step();
        swap();
        for (int i = 0; i < 8; i++) begin
            p = {i[5:0] + 6'd1, 2'(i % 3 + 1)};
            exp_q.push_back(p);
            read_px(9'h080 + i[AW-1:0], got);
            e = exp_q.pop_front();
            n_chk++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL b2b[%0d]: got %h, required %h", i, got, e);
            end
        end
        park();
        step();
    endtask

    task automatic test_swap_collision();
        logic [7:0] got;
        logic [7:0] e;
        obj_we  = 1'b1;
        obj_x   = 9'h040;
        obj_pxl = 8'hC6;
        HBD_n   = 1'b0;
        step();
        obj_pxl = 8'h5B;
        HBD_n   = 1'b1;
        step();
        obj_we = 1'b0;
        step();
        step();
        exp_q.push_back(8'hC6);
        read_px(9'h040, got);
        e = exp_q.pop_front();
        n_chk++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL collide_visible: got %h, required %h", got, e);
        end
        park();
        step();
        swap();
        exp_q.push_back(8'h5B);
        read_px(9'h040, got);
        e = exp_q.pop_front();
        n_chk++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL collide_hidden: got %h, required %h", got, e);
        end
        park();
        step();
    endtask

    task automatic test_cen_gating();
        logic [7:0] got;
        logic [7:0] e;
        int bad;
        wr(9'h050, 8'h9E);
        step();
        swap();
        park();
        step();
        cen = 1'b0;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            obj_we  = 1'b1;
            obj_x   = 9'h060;
            obj_pxl = 8'hFF;
            hdump   = (i % 2 == 1) ? 9'h050 : 9'h060;
            HBD_n   = (i % 2 == 1);
            step();
            if ({objc, objv} !== 8'h00 || busy !== 1'b0) bad++;
        end
        n_chk++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL cen_hold_out: %0d cycles changed output/busy, required 0", bad);
        end
        obj_we = 1'b0;
        HBD_n  = 1'b1;
        cen    = 1'b1;
        exp_q.push_back(8'h9E);
        read_px(9'h050, got);
        e = exp_q.pop_front();
        n_chk++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL cen_hold_ram: got %h, required %h", got, e);
        end
        park();
        step();
        swap();
        exp_q.push_back(8'h00);
        read_px(9'h060, got);
        e = exp_q.pop_front();
        n_chk++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL cen_hold_write: got %h, required %h", got, e);
        end
        park();
        step();
    endtask

    initial begin
        rst     = 1'b1;
        cen     = 1'b1;
        HBD_n   = 1'b1;
        hdump   = 9'h1FF;
        obj_we  = 1'b0;
        obj_x   = '0;
        obj_pxl = '0;
        step();
        step();
        step();
        rst = 1'b0;
        wait_ready("powerup_clear");

        test_reset();
        test_write_swap_read();
        test_transparent();
        test_priority();
        test_back_to_back();
        test_swap_collision();
        test_cen_gating();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/jtpopeye_objbuf.md
Name: jtpopeye_objbuf

Overview:
Double-buffered object line buffer that sits directly upstream of the colour mixer.
- During line N the object engine writes pixels for line N+1 into the hidden bank.
- The visible bank is read out by horizontal position and drives the mixer's objc/objv inputs.
- Every location is cleared after it is read, so the bank is empty when it becomes hidden again.

Parameters:
AW, 9, line-buffer address width; each bank holds 2**AW pixels.
CLRW, 8, pixel word width: {colour[5:0], value[1:0]}; value 0 means transparent.

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
cen  input  1  pixel clock enable; all state advances only when cen=1
HBD_n  input  1  horizontal blank, active low; its falling edge swaps the banks
hdump  input  AW  horizontal read position for the visible bank
obj_we  input  1  object pixel write strobe, sampled when cen=1
obj_x  input  AW  write address in the hidden bank
obj_pxl  input  CLRW  pixel to write, {colour, value}
objc  output  6  colour to the mixer
objv  output  2  pixel value to the mixer; 0 means no object pixel
busy  output  1  high while the reset clear runs; writes are ignored while high

Behaviour:
Reset and initial clear
- While rst=1: objc=0, objv=0, bank select disp=0, write pipeline empty, busy=1, clear counter=0.
- After rst falls, state CLEAR runs, one location per cen cycle. It walks both banks, zeroing 2*2**AW entries (1024 at default AW).
- During CLEAR: objc/objv are forced to 0 and obj_we is ignored.
- On the last entry: go to RUN and drop busy on the next cen cycle.
- Asserting rst at any point, including mid-CLEAR, restarts the sequence from counter 0.

Bank swap
- A registered copy of HBD_n detects the 1->0 edge. On the cen cycle where that edge is seen, disp toggles.
- The write pipeline stage committing in that same cycle still targets the old hidden bank. The swap applies to writes issued from the next cycle onward.

Read path, visible bank
- Registered read: objc/objv reflect the mem[disp][hdump] value sampled on the previous cen cycle, so latency is 1 cen cycle.
- In the cycle after each read, that location is written with 0 (read-then-clear).
- If hdump is unchanged across cycles, the second read returns 0. This is the intended behaviour.

Write path, hidden bank
- Two-stage pipeline.
- Stage 1: when obj_we=1, obj_pxl value!=0 and busy=0, latch obj_x and obj_pxl, then read mem[~disp][obj_x].
- Stage 2: write obj_pxl subject to the priority rule (see Optional Feature).
- Writes with value==0 are dropped, so a transparent pixel never overwrites.
- Back-to-back writes to the same address: stage 2 compares against the forwarded stage-2 data, not the stale RAM read.
- Full write throughput: one pixel per cen cycle.
- obj_x wraps modulo 2**AW.

Outputs while the visible bank is being cleared
- objc/objv show the stored data; no blanking is applied here. The mixer gates with HBD_n/VB_n.

Optional Feature:
Macro JTPOPEYE_OBJ_FIRSTWIN_EN.
- Defined: first written wins. Stage 2 writes only if the stored value field is 0, so earlier objects keep priority.
- Undefined: last written wins. Stage 2 always writes non-transparent pixels, and the read-before-write result is unused.

Test Plan:
- Reset clear: pre-fill RAM with 0xFF, pulse rst, then cen=1 continuously -> busy=1 for exactly 1024 cen cycles; afterwards every hdump in both banks reads objv=0.
- Write/swap/read: write obj_x=0x010, obj_pxl=0xA7, then HBD_n falling edge, then hdump=0x010 -> the next cen cycle gives objc=0x29, objv=3; a re-read of 0x010 gives objv=0.
- Transparent drop: write 0x20 pixel 0x55, then 0x20 pixel 0x54 (value 0), swap -> reads 0x55.
- Priority: write 0x30 pixel 0x41, then 0x30 pixel 0x82 back-to-back -> with FIRSTWIN_EN reads 0x41, without it reads 0x82.
- Swap collision: issue a write to 0x40 on the cycle of the HBD_n edge -> the pixel lands in the bank that becomes visible; a write issued one cycle later lands in the new hidden bank.
- cen gating: hold cen=0 for 5 cycles while toggling obj_we and hdump -> no RAM or output change.
